// File: rtl/psw_pkg.sv
// Shared definitions for the PSW add unit: 8051-style flag layout and the software write mask.
package psw_pkg;

    localparam int unsigned PSW_W   = 8;
    localparam int unsigned PSW_CY  = 7;
    localparam int unsigned PSW_AC  = 6;
    localparam int unsigned PSW_F0  = 5;
    localparam int unsigned PSW_RS1 = 4;
    localparam int unsigned PSW_RS0 = 3;
    localparam int unsigned PSW_OV  = 2;
    localparam int unsigned PSW_F1  = 1;
    localparam int unsigned PSW_P   = 0;

    // P is derived from the accumulator and never written by software
    localparam logic [PSW_W-1:0] PSW_WR_MASK = 8'hFE;

    typedef struct packed {
        logic cy;
        logic ac;
        logic f0;
        logic rs1;
        logic rs0;
        logic ov;
        logic f1;
        logic p;
    } psw_t;

endpackage

// File: rtl/psw_add_unit_flag_calc.sv
// Combinational 8-bit adder with carry-in producing the sum and the CY/AC/OV/P flags.
module psw_flag_calc (
    input  logic [7:0] acc,
    input  logic [7:0] operand,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cy,
    output logic       ac,
    output logic       ov,
    output logic       p
);

    logic [8:0] sum9;
    logic [4:0] low_nib;
    logic [7:0] low7;

    always_comb begin
        sum9    = 9'(acc) + 9'(operand) + 9'(cin);
        low_nib = 5'(acc[3:0]) + 5'(operand[3:0]) + 5'(cin);
        low7    = 8'(acc[6:0]) + 8'(operand[6:0]) + 8'(cin);
        sum     = sum9[7:0];
        cy      = sum9[8];
        ac      = low_nib[4];
        // carry into bit 7 versus carry out of bit 7
        ov      = low7[7] ^ sum9[8];
        p       = ^sum9[7:0];
    end

endmodule

// File: rtl/psw_add_unit.sv
// ADD/ADDC datapath owning the registered PSW, result and completed-op counter.
// Optional build macro PSW_STICKY_OV_EN turns F1 into a sticky overflow flag.
module psw_add_unit
    import psw_pkg::*;
#(
    parameter logic [7:0]  PSW_RST  = 8'h00,
    parameter int unsigned OP_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          acc,
    input  logic [7:0]          operand,
    input  logic                add_op,
    input  logic                addc_op,
    input  logic                psw_we,
    input  logic [7:0]          psw_wdata,
    output logic [7:0]          psw,
    output logic [7:0]          result,
    output logic                result_vld,
    output logic [OP_CNT_W-1:0] op_cnt
);

    psw_t       psw_q;
    psw_t       psw_d;
    logic [7:0] psw_raw;
    logic       cin_c;
    logic [7:0] sum_c;
    logic       cy_c;
    logic       ac_c;
    logic       ov_c;
    logic       p_c;

    assign psw_raw = psw_q;
    assign psw     = psw_raw;
    // carry-in always comes from the registered CY, never from psw_wdata
    assign cin_c   = addc_op & psw_q.cy;

    psw_flag_calc u_flag_calc (
        .acc     (acc),
        .operand (operand),
        .cin     (cin_c),
        .sum     (sum_c),
        .cy      (cy_c),
        .ac      (ac_c),
        .ov      (ov_c),
        .p       (p_c)
    );

    // Software write merges first; arithmetic flags from an add take precedence
    always_comb begin
        psw_d = psw_q;
        if (psw_we) begin
            psw_d = psw_t'((psw_wdata & PSW_WR_MASK) | (psw_raw & ~PSW_WR_MASK));
        end
        if (add_op) begin
            psw_d.cy = cy_c;
            psw_d.ac = ac_c;
            psw_d.ov = ov_c;
            psw_d.p  = p_c;
        end
`ifdef PSW_STICKY_OV_EN
        if (add_op && ov_c) begin
            psw_d.f1 = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psw_q      <= psw_t'({PSW_RST[7:1], 1'b0});
            result     <= 8'h00;
            result_vld <= 1'b0;
            op_cnt     <= '0;
        end else begin
            psw_q      <= psw_d;
            result_vld <= add_op;
            if (add_op) begin
                result <= sum_c;
                op_cnt <= op_cnt + OP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_psw_add_unit.sv
// Scoreboard bench for psw_add_unit: randomized and directed ADD/ADDC/PSW-write traffic.
module tb_psw_add_unit;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    acc;
    logic [7:0]    operand;
    logic          add_op;
    logic          addc_op;
    logic          psw_we;
    logic [7:0]    psw_wdata;
    logic [7:0]    psw;
    logic [7:0]    result;
    logic          result_vld;
    logic [CW-1:0] op_cnt;

    typedef struct {
        bit       vld;
        bit [7:0] res;
        bit [7:0] psw;
        int       cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    int       m_res;
    bit [7:0] m_psw;
    int       m_cnt;

    psw_add_unit #(
        .PSW_RST  (8'h00),
        .OP_CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc        (acc),
        .operand    (operand),
        .add_op     (add_op),
        .addc_op    (addc_op),
        .psw_we     (psw_we),
        .psw_wdata  (psw_wdata),
        .psw        (psw),
        .result     (result),
        .result_vld (result_vld),
        .op_cnt     (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_res = 0;
        m_psw = 8'h00;
        m_cnt = 0;
    endtask

    // Reference: plain integer arithmetic with signed-range overflow detection
    task automatic do_cycle(input bit add, input bit addc, input bit we,
                            input bit [7:0] wd, input bit [7:0] a, input bit [7:0] b);
        exp_t e;
        int   cin, s, sa, sb, ss;
        bit   ov;
        @(negedge clk);
        add_op = add; addc_op = addc; psw_we = we; psw_wdata = wd;
        acc = a; operand = b;
        cin = (addc && m_psw[7]) ? 1 : 0;
        if (we) m_psw = {wd[7:1], m_psw[0]};
        if (add) begin
            s  = int'(a) + int'(b) + cin;
            sa = (a > 127) ? int'(a) - 256 : int'(a);
            sb = (b > 127) ? int'(b) - 256 : int'(b);
            ss = sa + sb + cin;
            ov = (ss > 127) || (ss < -128);
            m_res    = s % 256;
            m_psw[7] = (s > 255);
            m_psw[6] = ((int'(a) % 16) + (int'(b) % 16) + cin) > 15;
            m_psw[2] = ov;
            m_psw[0] = ($countones(m_res) % 2) == 1;
`ifdef PSW_STICKY_OV_EN
            if (ov) m_psw[1] = 1'b1;
`endif
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
        e.vld = add;
        e.res = 8'(m_res);
        e.psw = m_psw;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    // Monitor: pops one expectation per clock after the active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_vld",    int'(result_vld), int'(e.vld));
                chk("sb_result", int'(result),     int'(e.res));
                chk("sb_psw",    int'(psw),        int'(e.psw));
                chk("sb_op_cnt", int'(op_cnt),     e.cnt);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        add_op = 0; addc_op = 0; psw_we = 0; psw_wdata = 0; acc = 0; operand = 0;
        model_reset();
        #1;
        chk("rst_psw", int'(psw), 0);
        chk("rst_vld", int'(result_vld), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();

        do_cycle(1, 0, 0, 8'h00, 8'h7F, 8'h01);
        @(posedge clk); #2;
        chk("add7f01_result", int'(result), 'h80);
        chk("add7f01_psw", int'(psw), 'h45);
        idle();

        do_cycle(1, 0, 0, 8'h00, 8'hFF, 8'h01);
        @(posedge clk); #2;
        chk("addff01_result", int'(result), 'h00);
        chk("addff01_psw", int'(psw), 'hC0);
        do_cycle(1, 1, 0, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #2;
        chk("addc_chain_result", int'(result), 'h01);
        chk("addc_chain_psw", int'(psw), 'h01);

        do_cycle(1, 0, 0, 8'h00, 8'h00, 8'h00);
        do_cycle(0, 0, 1, 8'hFF, 8'h00, 8'h00);
        @(posedge clk); #2;
        chk("we_ff_psw", int'(psw), 'hFE);
        do_cycle(0, 0, 1, 8'h00, 8'h00, 8'h00);
        do_cycle(1, 0, 1, 8'h18, 8'h01, 8'h01);
        @(posedge clk); #2;
        chk("we_add_result", int'(result), 'h02);
        chk("we_add_psw", int'(psw), 'h19);

        do_cycle(0, 0, 1, 8'h00, 8'h00, 8'h00);
        do_cycle(1, 0, 0, 8'h00, 8'h80, 8'h80);
        @(posedge clk); #2;
`ifdef PSW_STICKY_OV_EN
        chk("ov8080_psw", int'(psw), 'h86);
`else
        chk("ov8080_psw", int'(psw), 'h84);
`endif
        do_cycle(1, 0, 0, 8'h00, 8'h01, 8'h01);
        @(posedge clk); #2;
`ifdef PSW_STICKY_OV_EN
        chk("after_ov_psw", int'(psw), 'h03);
`else
        chk("after_ov_psw", int'(psw), 'h01);
`endif

        // Asynchronous reset in the middle of an issued add
        do_cycle(1, 1, 0, 8'h00, 8'h55, 8'hAA);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("midrst_psw", int'(psw), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_vld", int'(result_vld), 0);
        chk("midrst_op_cnt", int'(op_cnt), 0);
        add_op = 0; addc_op = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("inrst_op_cnt", int'(op_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();

        for (int i = 0; i < 16; i++) begin
            do_cycle(1, 1'($urandom_range(0, 1)), 0, 8'h00, 8'($urandom), 8'($urandom));
        end
        @(posedge clk); #2;
        chk("wrap_op_cnt", int'(op_cnt), 0);
        chk("wrap_vld", int'(result_vld), 1);

        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) < 2, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        idle();

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #3;
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psw_add_unit.md
Name: psw_add_unit

Overview:
- 8-bit add/add-with-carry datapath that responds on the PSW interface: consumes acc, operand and add_op, and owns the registered program status word.
- 8051-style PSW layout: bit7 CY, bit6 AC, bit5 F0, bit4 RS1, bit3 RS0, bit2 OV, bit1 F1, bit0 P.
- Sits behind the interface's driver side. Stimulus changes on negedge; PSW is sampled on posedge.

Parameters:
- PSW_RST, 8'h00: reset value of PSW bits 7:1. Bit 0 (P) always resets to 0.
- OP_CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  input  1  single clock, posedge active
- rst_n  input  1  asynchronous, active-low reset
- acc  input  8  accumulator operand A
- operand  input  8  operand B
- add_op  input  1  execute add this cycle
- addc_op  input  1  qualifies add_op: use PSW.CY as carry-in; ignored when add_op=0
- psw_we  input  1  software write of PSW
- psw_wdata  input  8  software write data
- psw  output  8  registered program status word
- result  output  8  registered sum (new accumulator value)
- result_vld  output  1  high for the cycle after each sampled add_op
- op_cnt  output  OP_CNT_W  count of completed adds; wraps

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation): psw={PSW_RST[7:1],1'b0}, result=0, result_vld=0, op_cnt=0. Ops in flight are discarded.
- Latency 1: add_op sampled at posedge N; result, psw and result_vld are valid after posedge N.
- cin = addc_op ? psw[7] : 0, using the current registered CY (pre-update value).
- sum9 = {1'b0,acc} + {1'b0,operand} + cin. Then:
  - result <= sum9[7:0]
  - CY <= sum9[8]
  - AC <= carry out of bit 3, i.e. (acc[3:0]+operand[3:0]+cin) > 15
  - OV <= carry into bit 7 XOR carry out of bit 7
  - P <= ^sum9[7:0]
  - F0, RS1, RS0 and F1 are unchanged by the add.
- Back-to-back ADDC chains correctly because CY is registered with 1-cycle latency. No bubble is required.
- add_op=0: result holds, result_vld=0, and psw holds unless psw_we=1.
- Consecutive add_op cycles keep result_vld continuously high.
- psw_we alone: psw[7:1] <= psw_wdata[7:1]. P is read-only and holds.
- psw_we and add_op in the same cycle:
  - CY, AC, OV and P come from the add.
  - F0, RS1, RS0 and F1 come from psw_wdata.
  - cin uses the old CY, not psw_wdata[7].
- op_cnt increments on every sampled add_op and wraps from all-ones to 0.
- No internal FSM beyond the registers. No X propagation is allowed: all outputs are driven from flops.

Optional Feature:
- Macro: PSW_STICKY_OV_EN.
- Defined: F1 (bit1) becomes sticky overflow. It sets on any add that produces OV=1. It clears only on reset or on psw_we with psw_wdata[1]=0. If set and clear coincide in the same cycle, set wins.
- Undefined: F1 is a plain software bit, written only by psw_we.

Decomposition:
- Package psw_pkg contains:
  - localparams for the bit indices (PSW_CY=7 … PSW_P=0)
  - a packed struct typedef psw_t matching the layout
  - the software-writable mask 8'hFE
- Sub-module psw_flag_calc: purely combinational. Inputs acc, operand, cin; outputs sum, cy, ac, ov, p.
- The top module holds all registers, the write-merge logic, the optional sticky logic and op_cnt.

Test Plan:
- Reset: assert rst_n=0 mid-stream with add_op=1 -> psw=00, result=00, result_vld=0, op_cnt=0 immediately (asynchronous). Outputs stay there until the first add after release.
- ADD 7F+01 -> result=80, psw=45 (AC, OV, P), result_vld=1 for one cycle.
- ADD FF+01 then ADDC 00+00 on the next cycle:
  - first op -> result=00, psw=C0
  - second op -> result=01, psw=01 (carry chained, CY cleared)
- psw_we=1, psw_wdata=FF alone from psw=00 -> psw=FE (P not writable).
- psw_we=1, psw_wdata=18 together with ADD 01+01 -> result=02, psw=19.
- ADD 80+80 then ADD 01+01:
  - with PSW_STICKY_OV_EN defined -> psw=86, then psw=03
  - with it undefined -> psw=84, then psw=01
- op_cnt wrap with OP_CNT_W=4: 16 consecutive add_op cycles -> op_cnt returns to 0, and result_vld stays high throughout.
